// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writeback, with a per-register pending-write scoreboard and contention counter.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  output logic [NREG-1:0] busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic [CW-1:0]   contention_cnt
);

  typedef enum logic {PRIO_ALU = 1'b0, PRIO_MEM = 1'b1} prio_t;

  prio_t           prio_reg;
  logic            rf_we_reg;
  logic [AW-1:0]   rf_a3_reg;
  logic [XLEN-1:0] rf_wd_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [CW-1:0]   cnt_reg;

  logic            grant_alu;
  logic            grant_mem;
  logic            xfer;
  logic [AW-1:0]   xfer_rd;
  logic [XLEN-1:0] xfer_data;

  assign grant_alu = alu_valid && (!mem_valid || prio_reg == PRIO_ALU);
  assign grant_mem = mem_valid && (!alu_valid || prio_reg == PRIO_MEM);
  assign xfer      = grant_alu || grant_mem;
  assign xfer_rd   = grant_alu ? alu_rd : mem_rd;
  assign xfer_data = grant_alu ? alu_data : mem_data;

  assign alu_ready      = grant_alu;
  assign mem_ready      = grant_mem;
  assign rf_we          = rf_we_reg;
  assign rf_a3          = rf_a3_reg;
  assign rf_wd          = rf_wd_reg;
  assign busy           = busy_reg;
  assign contention_cnt = cnt_reg;

  // A new reservation beats a same-edge clear: the reservation is the younger event.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = (alloc_valid && alloc_rd == AW'(gi)) ||
                               (busy_reg[gi] && !(xfer && xfer_rd == AW'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg  <= PRIO_ALU;
      rf_we_reg <= 1'b0;
      rf_a3_reg <= '0;
      rf_wd_reg <= '0;
      busy_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      busy_reg  <= busy_next;
      rf_we_reg <= xfer && (xfer_rd != '0);
      if (xfer) begin
        rf_a3_reg <= xfer_rd;
        rf_wd_reg <= xfer_data;
        prio_reg  <= grant_alu ? PRIO_MEM : PRIO_ALU;
      end
      if (alu_valid && mem_valid && cnt_reg != {CW{1'b1}})
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus queues expected register-file
// writes, an independent monitor pops and compares them as rf_we appears.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 16;

  logic            clk;
  logic            rst;
  logic            alu_valid, mem_valid, alloc_valid;
  logic            alu_ready, mem_ready, alu_ready2, mem_ready2;
  logic [AW-1:0]   alu_rd, mem_rd, alloc_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic [NREG-1:0] busy, busy2;
  logic            rf_we, rf_we2;
  logic [AW-1:0]   rf_a3, rf_a32;
  logic [XLEN-1:0] rf_wd, rf_wd2;
  logic [CW-1:0]   contention_cnt;
  logic [1:0]      contention_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] ad, md;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .busy(busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .contention_cnt(contention_cnt)
  );

  // Narrow-counter instance for saturation; shares all stimulus.
  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .CW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready2), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready2), .mem_rd(mem_rd), .mem_data(mem_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .busy(busy2),
    .rf_we(rf_we2), .rf_a3(rf_a32), .rf_wd(rf_wd2), .contention_cnt(contention_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [AW-1:0] r);
    alloc_valid = 1'b1;
    alloc_rd    = r;
    step();
    alloc_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got a3=%0d wd=%0h expected no write", rf_a3, rf_wd);
      end else begin
        logic [AW+XLEN-1:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(rf_a3), 64'(e[AW+XLEN-1:XLEN]));
        chk("write_data", 64'(rf_wd), 64'(e[XLEN-1:0]));
        $display("write a3=%0d wd=%08h", rf_a3, rf_wd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    alu_valid = 0; mem_valid = 0; alloc_valid = 0;
    alu_rd = 0; mem_rd = 0; alloc_rd = 0; alu_data = 0; mem_data = 0;
    #2;
    chk("reset_we", 64'(rf_we), 64'd0);
    chk("reset_a3", 64'(rf_a3), 64'd0);
    chk("reset_wd", 64'(rf_wd), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cnt", 64'(contention_cnt), 64'd0);
    step();
    rst = 1'b0;

    // Single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    #1;
    chk("single_alu_ready", 64'(alu_ready), 64'd1);
    chk("single_mem_ready", 64'(mem_ready), 64'd0);
    step();
    alu_valid = 0;
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_a3", 64'(rf_a3), 64'd5);
    chk("single_wd", 64'(rf_wd), 64'hDEADBEEF);
    step();
    chk("single_we_after", 64'(rf_we), 64'd0);

    // Contention: ALU, MEM, ALU, MEM
    do_reset();
    alu_rd = 3; mem_rd = 7; ad = 32'hA000_0000; md = 32'hB000_0000;
    alu_valid = 1; mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_data = ad; mem_data = md;
      #1;
      chk("cont_alu_ready", 64'(alu_ready), 64'((i % 2) == 0));
      chk("cont_mem_ready", 64'(mem_ready), 64'((i % 2) == 1));
      if ((i % 2) == 0) begin exp_q.push_back({5'd3, ad}); ad = ad + 1; end
      else begin exp_q.push_back({5'd7, md}); md = md + 1; end
      step();
    end
    alu_valid = 0; mem_valid = 0;
    #1;
    chk("cont_cnt", 64'(contention_cnt), 64'd4);
    step();
    chk("cont_cnt_hold", 64'(contention_cnt), 64'd4);

    // x0 write: accepted, no rf_we, busy untouched
    do_reset();
    alloc(5'd4);
    chk("x0_busy_pre", 64'(busy), 64'h10);
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
    #1;
    chk("x0_mem_ready", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 0;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_busy", 64'(busy), 64'h10);

    // Scoreboard: alloc 9, write 9 three cycles later
    do_reset();
    alloc(5'd9);
    chk("sb_busy_set", 64'(busy), 64'h200);
    step();
    chk("sb_busy_hold1", 64'(busy), 64'h200);
    step();
    chk("sb_busy_hold2", 64'(busy), 64'h200);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h0000_0099;
    exp_q.push_back({5'd9, 32'h0000_0099});
    #1;
    chk("sb_alu_ready", 64'(alu_ready), 64'd1);
    chk("sb_busy_before_xfer", 64'(busy), 64'h200);
    step();
    alu_valid = 0;
    chk("sb_busy_clear", 64'(busy), 64'h0);
    // Same-edge alloc and write: reservation wins
    alloc_valid = 1; alloc_rd = 9;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h0000_0100;
    exp_q.push_back({5'd9, 32'h0000_0100});
    step();
    alloc_valid = 0; alu_valid = 0;
    chk("sb_set_wins", 64'(busy), 64'h200);
    step();

    // Same rd from both sides: two writes, busy clears at first transfer
    do_reset();
    alloc(5'd12);
    alu_valid = 1; mem_valid = 1; alu_rd = 12; mem_rd = 12;
    alu_data = 32'h11; mem_data = 32'h22;
    exp_q.push_back({5'd12, 32'h11});
    exp_q.push_back({5'd12, 32'h22});
    #1;
    chk("same_rd_alu_first", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 0;
    chk("same_rd_busy_clear", 64'(busy), 64'h0);
    chk("same_rd_mem_second", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 0;
    step();

    // Saturation on the 2-bit counter
    do_reset();
    alu_valid = 1; mem_valid = 1; alu_rd = 0; mem_rd = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) chk("sat_cnt_mid", 64'(contention_cnt2), 64'd2);
    end
    alu_valid = 0; mem_valid = 0;
    chk("sat_cnt2", 64'(contention_cnt2), 64'd3);
    chk("sat_cnt16", 64'(contention_cnt), 64'd6);

    // Async reset mid-cycle with a write in flight
    do_reset();
    alloc(5'd4);
    alloc(5'd9);
    alu_valid = 1; mem_valid = 1; alu_rd = 6; mem_rd = 0;
    alu_data = 32'h6666; mem_data = 32'h0;
    step();
    alu_valid = 0; mem_valid = 0;
    chk("ar_pre_we", 64'(rf_we), 64'd1);
    chk("ar_pre_busy", 64'(busy), 64'h210);
    chk("ar_pre_cnt", 64'(contention_cnt), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_we", 64'(rf_we), 64'd0);
    chk("ar_busy", 64'(busy), 64'h0);
    chk("ar_cnt", 64'(contention_cnt), 64'd0);
    step();
    rst = 1'b0;
    alu_valid = 1; mem_valid = 1; alu_rd = 3; mem_rd = 7;
    alu_data = 32'h3333; mem_data = 32'h7777;
    exp_q.push_back({5'd3, 32'h3333});
    #1;
    chk("ar_tie_alu", 64'(alu_ready), 64'd1);
    chk("ar_tie_mem", 64'(mem_ready), 64'd0);
    step();
    alu_valid = 0; mem_valid = 0;
    step();
    step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
